// File: rtl/parking_pkg.sv
// Shared definitions for the parking exit path: FSM encoding, slot geometry
// and default gate/lockout durations.
package parking_pkg;

   localparam int SLOT_W            = 3;
   localparam int NUM_SLOTS         = 8;
   localparam int GATE_OPEN_DEFAULT = 16;
   localparam int LOCKOUT_DEFAULT   = 64;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DECODE = 3'd1,
      S_CHECK  = 3'd2,
      S_OPEN   = 3'd3,
      S_LOCK   = 3'd4
   } state_t;

   // Width of a down-counter that must hold (max(a, b) - 1).
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/exit_token_decoder.sv
// Combinational token decrypt: park number is token XOR pattern, forced to
// zero while not enabled so the result only moves when it is consumed.
module exit_token_decoder
   import parking_pkg::*;
(
   input  logic              en,
   input  logic [SLOT_W-1:0] token,
   input  logic [SLOT_W-1:0] pattern,
   output logic [SLOT_W-1:0] park_number
);

   assign park_number = en ? (token ^ pattern) : '0;

endmodule

// File: rtl/parking_exit_ctrl.sv
// Exit-path sequencer: latch request, decode token, check occupancy, then
// release the slot and hold the gate open. Define PARKING_EXIT_LOCKOUT_EN for reject lockout.
module parking_exit_ctrl
   import parking_pkg::*;
#(
   parameter int GATE_OPEN_CYCLES = GATE_OPEN_DEFAULT,
   parameter int LOCKOUT_CYCLES   = LOCKOUT_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 exit_req,
   input  logic [SLOT_W-1:0]    token,
   input  logic [SLOT_W-1:0]    pattern,
   input  logic [NUM_SLOTS-1:0] occupied,
   output logic                 busy,
   output logic                 exit_ack,
   output logic                 exit_reject,
   output logic                 free_valid,
   output logic [SLOT_W-1:0]    free_slot,
   output logic                 gate_open,
   output logic                 locked,
   output state_t               state
);

   // One counter serves both the gate hold and the lockout hold.
   localparam int CNT_W = cnt_width(GATE_OPEN_CYCLES, LOCKOUT_CYCLES);
   localparam logic [CNT_W-1:0] GATE_LOAD = CNT_W'(GATE_OPEN_CYCLES - 1);

   state_t            state_n;
   logic [SLOT_W-1:0] token_q, token_n;
   logic [SLOT_W-1:0] pattern_q, pattern_n;
   logic [SLOT_W-1:0] park_q, park_n;
   logic [SLOT_W-1:0] decoded;
   logic [SLOT_W-1:0] slot_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic              ack_n, reject_n, fv_n, gate_n;

`ifdef PARKING_EXIT_LOCKOUT_EN
   localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
   logic [1:0] rej_cnt, rej_n;
   logic       locked_q, locked_n;
   assign locked = locked_q;
`else
   assign locked = 1'b0;
`endif

   exit_token_decoder u_decoder (
      .en          (state == S_DECODE),
      .token       (token_q),
      .pattern     (pattern_q),
      .park_number (decoded)
   );

   assign busy = (state != S_IDLE);

   always_comb begin
      state_n   = state;
      token_n   = token_q;
      pattern_n = pattern_q;
      park_n    = park_q;
      cnt_n     = cnt;
      slot_n    = free_slot;
      gate_n    = gate_open;
      ack_n     = 1'b0;
      reject_n  = 1'b0;
      fv_n      = 1'b0;
`ifdef PARKING_EXIT_LOCKOUT_EN
      rej_n     = rej_cnt;
      locked_n  = locked_q;
`endif
      case (state)
         S_IDLE: begin
            if (exit_req) begin
               token_n   = token;
               pattern_n = pattern;
               state_n   = S_DECODE;
            end
         end
         S_DECODE: begin
            park_n  = decoded;
            state_n = S_CHECK;
         end
         S_CHECK: begin
            if (occupied[park_q]) begin
               ack_n   = 1'b1;
               fv_n    = 1'b1;
               slot_n  = park_q;
               gate_n  = 1'b1;
               cnt_n   = GATE_LOAD;
               state_n = S_OPEN;
`ifdef PARKING_EXIT_LOCKOUT_EN
               rej_n   = 2'd0;
`endif
            end else begin
               reject_n = 1'b1;
               state_n  = S_IDLE;
`ifdef PARKING_EXIT_LOCKOUT_EN
               // Third consecutive reject: this one diverts into lockout.
               if (rej_cnt == 2'd2) begin
                  state_n  = S_LOCK;
                  locked_n = 1'b1;
                  cnt_n    = LOCK_LOAD;
               end else begin
                  rej_n = rej_cnt + 2'd1;
               end
`endif
            end
         end
         S_OPEN: begin
            if (cnt == '0) begin
               gate_n  = 1'b0;
               state_n = S_IDLE;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
`ifdef PARKING_EXIT_LOCKOUT_EN
         S_LOCK: begin
            if (cnt == '0) begin
               locked_n = 1'b0;
               rej_n    = 2'd0;
               state_n  = S_IDLE;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
`endif
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         token_q     <= '0;
         pattern_q   <= '0;
         park_q      <= '0;
         cnt         <= '0;
         free_slot   <= '0;
         gate_open   <= 1'b0;
         exit_ack    <= 1'b0;
         exit_reject <= 1'b0;
         free_valid  <= 1'b0;
`ifdef PARKING_EXIT_LOCKOUT_EN
         rej_cnt     <= 2'd0;
         locked_q    <= 1'b0;
`endif
      end else begin
         state       <= state_n;
         token_q     <= token_n;
         pattern_q   <= pattern_n;
         park_q      <= park_n;
         cnt         <= cnt_n;
         free_slot   <= slot_n;
         gate_open   <= gate_n;
         exit_ack    <= ack_n;
         exit_reject <= reject_n;
         free_valid  <= fv_n;
`ifdef PARKING_EXIT_LOCKOUT_EN
         rej_cnt     <= rej_n;
         locked_q    <= locked_n;
`endif
      end
   end

endmodule

// File: tb/tb_parking_exit_ctrl.sv
// Directed bench for parking_exit_ctrl: valid exit, reject, held request,
// mid-gate reset, decode sweep and (with PARKING_EXIT_LOCKOUT_EN) lockout.
module tb_parking_exit_ctrl;
   import parking_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       exit_req = 1'b0;
   logic [2:0] token = '0;
   logic [2:0] pattern = '0;
   logic [7:0] occupied = '0;
   logic       busy, exit_ack, exit_reject, free_valid, gate_open, locked;
   logic [2:0] free_slot;
   state_t     state;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   parking_exit_ctrl #(
      .GATE_OPEN_CYCLES (16),
      .LOCKOUT_CYCLES   (64)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .exit_req    (exit_req),
      .token       (token),
      .pattern     (pattern),
      .occupied    (occupied),
      .busy        (busy),
      .exit_ack    (exit_ack),
      .exit_reject (exit_reject),
      .free_valid  (free_valid),
      .free_slot   (free_slot),
      .gate_open   (gate_open),
      .locked      (locked),
      .state       (state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_req(input logic [2:0] t, input logic [2:0] p, input logic [7:0] occ);
      token    = t;
      pattern  = p;
      occupied = occ;
      exit_req = 1'b1;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (state !== S_IDLE && n < budget) begin
         tick();
         n++;
      end
      vec_cnt++;
      if (state !== S_IDLE) begin
         $display("FAIL wait_idle: state %0d, required %0d within %0d cycles", state, S_IDLE, budget);
         err_cnt++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start_req(3'd0, 3'd2, 8'hFF);
      tick();
      tick();
      vec_cnt++;
      if ({busy, exit_ack, exit_reject, free_valid, gate_open, locked, free_slot} !== 9'd0) begin
         $display("FAIL reset_outputs: got %b required 0", {busy, exit_ack, exit_reject, free_valid, gate_open, locked, free_slot});
         err_cnt++;
      end
      vec_cnt++;
      if (state !== S_IDLE) begin
         $display("FAIL reset_state: got %0d required %0d", state, S_IDLE);
         err_cnt++;
      end
      exit_req = 1'b0;
      reset    = 1'b0;
      tick();
   endtask

   task automatic test_valid_exit();
      int gate_cycles;
      start_req(3'b000, 3'b010, 8'b0000_0100);
      tick();
      vec_cnt++;
      if (state !== S_DECODE || exit_ack !== 1'b0) begin
         $display("FAIL valid_decode: state %0d ack %b, required %0d ack 0", state, exit_ack, S_DECODE);
         err_cnt++;
      end
      tick();
      vec_cnt++;
      if (state !== S_CHECK || exit_ack !== 1'b0 || busy !== 1'b1) begin
         $display("FAIL valid_check: state %0d ack %b busy %b, required %0d 0 1", state, exit_ack, busy, S_CHECK);
         err_cnt++;
      end
      tick();
      vec_cnt++;
      if ({exit_ack, free_valid, exit_reject, gate_open, free_slot} !== {4'b1101, 3'd2}) begin
         $display("FAIL valid_ack: ack/fv/rej/gate/slot got %b required %b", {exit_ack, free_valid, exit_reject, gate_open, free_slot}, {4'b1101, 3'd2});
         err_cnt++;
      end
      exit_req = 1'b0;
      occupied = 8'h00;
      tick();
      vec_cnt++;
      if (exit_ack !== 1'b0 || free_valid !== 1'b0 || gate_open !== 1'b1) begin
         $display("FAIL valid_pulse_width: ack %b fv %b gate %b, required 0 0 1", exit_ack, free_valid, gate_open);
         err_cnt++;
      end
      gate_cycles = 2;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (!gate_open) break;
         gate_cycles++;
      end
      vec_cnt++;
      if (gate_cycles != 16) begin
         $display("FAIL valid_gate_len: got %0d required 16", gate_cycles);
         err_cnt++;
      end
      vec_cnt++;
      if (state !== S_IDLE || busy !== 1'b0 || free_slot !== 3'd2) begin
         $display("FAIL valid_return: state %0d busy %b slot %0d, required %0d 0 2", state, busy, free_slot, S_IDLE);
         err_cnt++;
      end
   endtask

   task automatic test_reject();
      // Slot 5 looks occupied at request time but is empty when CHECK samples.
      start_req(3'b111, 3'b010, 8'h20);
      tick();
      occupied = 8'h00;
      tick();
      tick();
      vec_cnt++;
      if ({exit_reject, exit_ack, free_valid, gate_open} !== 4'b1000) begin
         $display("FAIL reject_pulse: rej/ack/fv/gate got %b required 1000", {exit_reject, exit_ack, free_valid, gate_open});
         err_cnt++;
      end
      vec_cnt++;
      if (state !== S_IDLE || busy !== 1'b0 || free_slot !== 3'd2) begin
         $display("FAIL reject_idle: state %0d busy %b slot %0d, required %0d 0 2", state, busy, free_slot, S_IDLE);
         err_cnt++;
      end
      exit_req = 1'b0;
      tick();
      vec_cnt++;
      if (exit_reject !== 1'b0 || gate_open !== 1'b0) begin
         $display("FAIL reject_single: rej %b gate %b required 0 0", exit_reject, gate_open);
         err_cnt++;
      end
   endtask

   task automatic test_held_request();
      int gate_cycles;
      int resp;
      start_req(3'b001, 3'b010, 8'h08);
      tick();
      tick();
      tick();
      vec_cnt++;
      if (exit_ack !== 1'b1 || free_slot !== 3'd3) begin
         $display("FAIL held_first_ack: ack %b slot %0d required 1 3", exit_ack, free_slot);
         err_cnt++;
      end
      token    = 3'b000;
      occupied = 8'h04;
      gate_cycles = 1;
      resp = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (exit_ack || exit_reject) resp++;
         if (!gate_open) break;
         gate_cycles++;
      end
      vec_cnt++;
      if (gate_cycles != 16 || resp != 0) begin
         $display("FAIL held_open: gate %0d resp %0d required 16 0", gate_cycles, resp);
         err_cnt++;
      end
      vec_cnt++;
      if (state !== S_IDLE) begin
         $display("FAIL held_idle: state %0d required %0d", state, S_IDLE);
         err_cnt++;
      end
      tick();
      vec_cnt++;
      if (state !== S_DECODE) begin
         $display("FAIL held_redecode: state %0d required %0d", state, S_DECODE);
         err_cnt++;
      end
      tick();
      tick();
      vec_cnt++;
      if (exit_ack !== 1'b1 || free_slot !== 3'd2) begin
         $display("FAIL held_second_ack: ack %b slot %0d required 1 2", exit_ack, free_slot);
         err_cnt++;
      end
      exit_req = 1'b0;
      wait_idle(40);
   endtask

   task automatic test_reset_mid_open();
      start_req(3'b000, 3'b010, 8'h04);
      tick();
      tick();
      tick();
      exit_req = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      vec_cnt++;
      if (gate_open !== 1'b1 || state !== S_OPEN) begin
         $display("FAIL midreset_setup: gate %b state %0d required 1 %0d", gate_open, state, S_OPEN);
         err_cnt++;
      end
      reset = 1'b1;
      tick();
      vec_cnt++;
      if ({busy, exit_ack, exit_reject, free_valid, gate_open, locked, free_slot} !== 9'd0 || state !== S_IDLE) begin
         $display("FAIL midreset_clear: outs %b state %0d required 0 %0d", {busy, exit_ack, exit_reject, free_valid, gate_open, locked, free_slot}, state, S_IDLE);
         err_cnt++;
      end
      reset = 1'b0;
      tick();
      vec_cnt++;
      if (busy !== 1'b0 || gate_open !== 1'b0 || free_valid !== 1'b0) begin
         $display("FAIL midreset_after: busy %b gate %b fv %b required 0 0 0", busy, gate_open, free_valid);
         err_cnt++;
      end
   endtask

   task automatic test_sweep();
      logic [2:0] exp_tab [8];
      exp_tab = '{3'd2, 3'd3, 3'd0, 3'd1, 3'd6, 3'd7, 3'd4, 3'd5};
      for (int t = 0; t < 8; t++) begin
         start_req(3'(t), 3'b010, 8'hFF);
         tick();
         tick();
         tick();
         vec_cnt++;
         if (exit_ack !== 1'b1 || free_valid !== 1'b1 || free_slot !== exp_tab[t]) begin
            $display("FAIL sweep_token%0d: ack %b fv %b slot %0d required 1 1 %0d", t, exit_ack, free_valid, free_slot, exp_tab[t]);
            err_cnt++;
         end
         exit_req = 1'b0;
         wait_idle(40);
      end
   endtask

`ifdef PARKING_EXIT_LOCKOUT_EN
   task automatic test_lockout();
      int lock_cycles;
      int resp;
      for (int r = 0; r < 2; r++) begin
         start_req(3'b111, 3'b010, 8'h00);
         tick();
         tick();
         tick();
         vec_cnt++;
         if (exit_reject !== 1'b1 || state !== S_IDLE || locked !== 1'b0) begin
            $display("FAIL lock_reject%0d: rej %b state %0d locked %b required 1 %0d 0", r, exit_reject, state, locked, S_IDLE);
            err_cnt++;
         end
         exit_req = 1'b0;
         tick();
      end
      start_req(3'b111, 3'b010, 8'h00);
      tick();
      tick();
      tick();
      vec_cnt++;
      if (exit_reject !== 1'b1 || state !== S_LOCK || locked !== 1'b1 || busy !== 1'b1) begin
         $display("FAIL lock_enter: rej %b state %0d locked %b busy %b required 1 %0d 1 1", exit_reject, state, locked, busy, S_LOCK);
         err_cnt++;
      end
      exit_req = 1'b0;
      lock_cycles = 1;
      resp = 0;
      for (int i = 0; i < 200; i++) begin
         if (i == 10) start_req(3'b000, 3'b010, 8'h04);
         tick();
         if (exit_ack || exit_reject) resp++;
         if (!locked) break;
         lock_cycles++;
      end
      vec_cnt++;
      if (lock_cycles != 64 || resp != 0) begin
         $display("FAIL lock_len: cycles %0d resp %0d required 64 0", lock_cycles, resp);
         err_cnt++;
      end
      tick();
      tick();
      tick();
      vec_cnt++;
      if (exit_ack !== 1'b1 || free_slot !== 3'd2 || locked !== 1'b0) begin
         $display("FAIL lock_resume: ack %b slot %0d locked %b required 1 2 0", exit_ack, free_slot, locked);
         err_cnt++;
      end
      exit_req = 1'b0;
      wait_idle(40);
   endtask
`else
   task automatic test_no_lockout();
      for (int r = 0; r < 4; r++) begin
         start_req(3'b111, 3'b010, 8'h00);
         tick();
         tick();
         tick();
         vec_cnt++;
         if (exit_reject !== 1'b1 || state !== S_IDLE || locked !== 1'b0) begin
            $display("FAIL nolock_reject%0d: rej %b state %0d locked %b required 1 %0d 0", r, exit_reject, state, locked, S_IDLE);
            err_cnt++;
         end
         exit_req = 1'b0;
         tick();
      end
      start_req(3'b000, 3'b010, 8'h04);
      tick();
      tick();
      tick();
      vec_cnt++;
      if (exit_ack !== 1'b1 || free_slot !== 3'd2 || locked !== 1'b0) begin
         $display("FAIL nolock_accept: ack %b slot %0d locked %b required 1 2 0", exit_ack, free_slot, locked);
         err_cnt++;
      end
      exit_req = 1'b0;
      wait_idle(40);
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_valid_exit();
      test_reject();
      test_held_request();
      test_reset_mid_open();
      test_sweep();
`ifdef PARKING_EXIT_LOCKOUT_EN
      test_lockout();
`else
      test_no_lockout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
